// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared types and constants for the PSRAM CR access sequencer
package psram_pkg;

  // Kind of bus access performed in one slot of a CR transaction
  typedef enum logic [1:0] {
    ACC_RD,
    ACC_WR_IDX,
    ACC_WR_DATA
  } acc_kind_e;

  // Sequencer states
  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } seq_state_e;

  // Tick at which chip select and address are asserted
  localparam int T_CS  = 0;
  // Tick at which the read or write strobe falls
  localparam int T_STB = 1;

  // Tick at which everything is released; leaves one idle tick per access
  function automatic int t_end(input int cycle_len);
    return cycle_len - 2;
  endfunction

  // Inactive level of every active-low bus control
  localparam logic CTRL_OFF = 1'b1;
  // Address presented while idle
  localparam logic ADDR_IDLE_BIT = 1'b0;

  // Access kind for slot a: unlock reads, then the index write, then the CR data access
  function automatic acc_kind_e acc_kind(input int a, input int acc_num, input logic rw);
    acc_kind_e k;
    if (a == acc_num - 2)
      k = ACC_WR_IDX;
    else if (a == acc_num - 1 && !rw)
      k = ACC_WR_DATA;
    else
      k = ACC_RD;
    return k;
  endfunction

endpackage

// File: rtl/psram_cycle_timer.sv
// rtl/psram_cycle_timer.sv - tick and access-slot counters for one CR transaction
module psram_cycle_timer #(
  parameter  int CYCLE_LEN = 8,
  parameter  int ACC_NUM   = 4,
  localparam int T_W       = $clog2(CYCLE_LEN),
  localparam int A_W       = $clog2(ACC_NUM)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic           run,
  output logic [T_W-1:0] t,
  output logic [A_W-1:0] a,
  output logic           last_tick,
  output logic           last_access
);

  assign last_tick   = (t == T_W'(CYCLE_LEN - 1));
  assign last_access = (a == A_W'(ACC_NUM - 1));

  // Tick counter wraps every access; slot counter steps on each wrap
  always_ff @(posedge clk) begin
    if (clr || start) begin
      t <= '0;
      a <= '0;
    end else if (run) begin
      if (last_tick) begin
        t <= '0;
        a <= last_access ? '0 : a + A_W'(1);
      end else begin
        t <= t + T_W'(1);
      end
    end
  end

endmodule

// File: rtl/psram_cr_seq.sv
// rtl/psram_cr_seq.sv - PSRAM configuration-register unlock/access sequencer
module psram_cr_seq
  import psram_pkg::*;
#(
  parameter  int ADDR_W    = 25,
  parameter  int DATA_W    = 16,
  parameter  int CS_NUM    = 2,
  parameter  int CYCLE_LEN = 8,
  parameter  int ACC_NUM   = 4,
  localparam int CS_W      = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                dt_req,
  input  logic                rw,
  input  logic [CS_W-1:0]     cs_sel,
  input  logic [ADDR_W-1:0]   max_addr,
  input  logic [DATA_W-1:0]   reg_addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic                dt_ack,
  output logic                busy,
  output logic                overrun,
  output logic [DATA_W-1:0]   data_out,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] nbyte_en,
  output logic [CS_NUM-1:0]   ncs,
  output logic [CS_NUM-1:0]   noe,
  output logic                nwe,
  inout  wire  [DATA_W-1:0]   data
);

  localparam int T_W = $clog2(CYCLE_LEN);
  localparam int A_W = $clog2(ACC_NUM);
  localparam logic [T_W-1:0] TK_CS  = T_W'(T_CS);
  localparam logic [T_W-1:0] TK_STB = T_W'(T_STB);
  localparam logic [T_W-1:0] TK_END = T_W'(t_end(CYCLE_LEN));

  seq_state_e        state;
  logic              req_q;
  logic              rw_q;
  logic [CS_W-1:0]   sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] drv_q;
  logic              drv_en;
  logic [T_W-1:0]    t;
  logic [A_W-1:0]    a;
  logic              last_tick;
  logic              last_access;
  logic              req_edge;
  logic              start;
  acc_kind_e         kind;
  logic [CS_NUM-1:0] sel_mask_n;

  assign req_edge   = dt_req && !req_q;
  assign start      = (state == ST_IDLE) && req_edge;
  assign kind       = acc_kind(int'(a), ACC_NUM, rw_q);
  assign sel_mask_n = ~(CS_NUM'(1) << sel_q);
  assign data       = drv_en ? drv_q : {DATA_W{1'bz}};

  psram_cycle_timer #(
    .CYCLE_LEN (CYCLE_LEN),
    .ACC_NUM   (ACC_NUM)
  ) u_timer (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .run         (state == ST_ACTIVE),
    .t           (t),
    .a           (a),
    .last_tick   (last_tick),
    .last_access (last_access)
  );

  // Previous request level; tracked even through clr so a held request never restarts
  always_ff @(posedge clk) begin
    req_q <= dt_req;
  end

  // Transaction FSM with registered bus controls, driven by the current tick
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      dt_ack   <= 1'b0;
      overrun  <= 1'b0;
      rw_q     <= 1'b0;
      sel_q    <= '0;
      wdata_q  <= '0;
      drv_q    <= '0;
      drv_en   <= 1'b0;
      data_out <= '0;
      address  <= {ADDR_W{ADDR_IDLE_BIT}};
      nbyte_en <= {(DATA_W/8){CTRL_OFF}};
      ncs      <= {CS_NUM{CTRL_OFF}};
      noe      <= {CS_NUM{CTRL_OFF}};
      nwe      <= CTRL_OFF;
    end else begin
      dt_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_ACTIVE;
            busy    <= 1'b1;
            rw_q    <= rw;
            sel_q   <= cs_sel;
            wdata_q <= data_in;
          end
        end
        ST_ACTIVE: begin
          if (req_edge)
            overrun <= 1'b1;
          if (t == TK_CS) begin
            ncs      <= sel_mask_n;
            nbyte_en <= '0;
            address  <= max_addr;
            if (kind != ACC_RD) begin
              drv_q  <= (kind == ACC_WR_IDX) ? reg_addr : wdata_q;
              drv_en <= 1'b1;
            end
          end else if (t == TK_STB) begin
            if (kind == ACC_RD)
              noe <= sel_mask_n;
            else
              nwe <= 1'b0;
          end else if (t == TK_END) begin
            ncs      <= {CS_NUM{CTRL_OFF}};
            noe      <= {CS_NUM{CTRL_OFF}};
            nwe      <= CTRL_OFF;
            nbyte_en <= {(DATA_W/8){CTRL_OFF}};
            drv_en   <= 1'b0;
            // Bus is still driven by the memory at this edge, strobes rise after it
            if (last_access && rw_q)
              data_out <= data;
          end
          if (last_tick && last_access) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            dt_ack <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
